// File: rtl/reorder_pipe_pkg.sv
// rtl/reorder_pipe_pkg.sv - mode encodings, occupancy width and parity helper for reorder_rom_pipe
package reorder_pipe_pkg;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  // Widest channel word the parity helper covers; narrower words are zero-extended.
  localparam int PAR_MAX_W = 1024;

  function automatic int occWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic evenParity(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/reorder_pipe_stage.sv
// rtl/reorder_pipe_stage.sv - one valid/payload register slice of the reorder ROM pipeline
module reorder_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         upValid,
  input  logic [W-1:0] upPayload,
  input  logic         downReady,
  output logic         ready,
  output logic         valid,
  output logic [W-1:0] payload
);

  assign ready = !valid || downReady;

  // Payload only moves on a real load, so a stalled or flushed slice keeps its word.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      payload <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (ready) begin
        valid <= upValid;
      end
      if (ready && upValid && !flush) begin
        payload <= upPayload;
      end
    end
  end

endmodule

// File: rtl/reorder_rom_pipe.sv
// rtl/reorder_rom_pipe.sv - flow-controlled DEPTH-stage pipe for forward/inverse reorder ROM words
// Optional per-channel parity carry and check with REORDER_PIPE_PARITY_EN.
module reorder_rom_pipe
  import reorder_pipe_pkg::*;
#(
  parameter int CH    = 4,
  parameter int DW    = 128,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic                         mode_i,
  input  logic [CH*DW-1:0]             fwd_data_i,
  input  logic [CH*DW-1:0]             inv_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [CH*DW-1:0]             out_data_o,
  output logic                         out_mode_o,
  output logic [occWidth(DEPTH)-1:0]   occ_o
`ifdef REORDER_PIPE_PARITY_EN
  ,
  output logic                         par_err_o
`endif
);

  localparam int OCC_W = occWidth(DEPTH);
  localparam int DATA_W = CH * DW;
`ifdef REORDER_PIPE_PARITY_EN
  localparam int PW = DATA_W + 1 + CH;
`else
  localparam int PW = DATA_W + 1;
`endif

  logic [DATA_W-1:0] muxData;
  logic [PW-1:0]     inPayload;
  logic              stValid   [DEPTH];
  logic              stReady   [DEPTH];
  logic [PW-1:0]     stPayload [DEPTH];
  logic              accept;
  logic              outHs;

  assign muxData = (mode_i == MODE_INV) ? inv_data_i : fwd_data_i;

`ifdef REORDER_PIPE_PARITY_EN
  logic [CH-1:0] inPar;
  always_comb begin
    inPar = '0;
    for (int k = 0; k < CH; k++) begin
      inPar[k] = evenParity(PAR_MAX_W'(muxData[k*DW +: DW]));
    end
  end
  assign inPayload = {inPar, mode_i, muxData};
`else
  assign inPayload = {mode_i, muxData};
`endif

  for (genvar s = 0; s < DEPTH; s++) begin : gStage
    logic          upV;
    logic [PW-1:0] upP;
    logic          downR;

    if (s == 0) begin : gHead
      assign upV = in_valid_i && !flush_i;
      assign upP = inPayload;
    end else begin : gBody
      assign upV = stValid[s-1];
      assign upP = stPayload[s-1];
    end

    if (s == DEPTH - 1) begin : gTail
      assign downR = out_ready_i;
    end else begin : gLink
      assign downR = stReady[s+1];
    end

    reorder_pipe_stage #(.W(PW)) uStage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush_i),
      .upValid  (upV),
      .upPayload(upP),
      .downReady(downR),
      .ready    (stReady[s]),
      .valid    (stValid[s]),
      .payload  (stPayload[s])
    );
  end

  assign in_ready_o  = stReady[0] && !flush_i && !rst;
  assign out_valid_o = stValid[DEPTH-1];
  assign out_data_o  = stPayload[DEPTH-1][DATA_W-1:0];
  assign out_mode_o  = stPayload[DEPTH-1][DATA_W];

  assign accept = in_valid_i && in_ready_o;
  assign outHs  = out_valid_o && out_ready_i;

  // Counter mirrors popcount(v) without an adder tree over the stages.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      occ_o <= '0;
    end else begin
      occ_o <= occ_o + OCC_W'(accept) - OCC_W'(outHs);
    end
  end

`ifdef REORDER_PIPE_PARITY_EN
  logic [CH-1:0] parMiss;
  always_comb begin
    parMiss = '0;
    for (int k = 0; k < CH; k++) begin
      parMiss[k] = evenParity(PAR_MAX_W'(out_data_o[k*DW +: DW])) ^ stPayload[DEPTH-1][DATA_W+1+k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_o <= 1'b0;
    end else if (outHs && (|parMiss)) begin
      par_err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_reorder_rom_pipe.sv
// tb/tb_reorder_rom_pipe.sv - directed table and sequence checks for reorder_rom_pipe
module tb_reorder_rom_pipe;

  localparam int CH = 4;
  localparam int DW = 128;
  localparam int W  = CH * DW;

  typedef struct {
    logic         inV;
    logic         md;
    logic [W-1:0] fwd;
    logic [W-1:0] inv;
    logic         expV;
    logic         expMode;
    logic [W-1:0] expData;
    logic [1:0]   expOcc;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         inValid;
  logic         mode;
  logic [W-1:0] fwd;
  logic [W-1:0] inv;
  logic         outReady;

  logic         aReady, aValid, aMode;
  logic [W-1:0] aData;
  logic [1:0]   aOcc;
  logic         bReady, bValid, bMode;
  logic [W-1:0] bData;
  logic [2:0]   bOcc;
`ifdef REORDER_PIPE_PARITY_EN
  logic         aPar, bPar;
`endif

  int errs;
  int checks;

  reorder_rom_pipe #(.CH(CH), .DW(DW), .DEPTH(2)) aDut (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(inValid), .in_ready_o(aReady),
    .mode_i(mode), .fwd_data_i(fwd), .inv_data_i(inv), .out_valid_o(aValid),
    .out_ready_i(outReady), .out_data_o(aData), .out_mode_o(aMode), .occ_o(aOcc)
`ifdef REORDER_PIPE_PARITY_EN
    , .par_err_o(aPar)
`endif
  );

  reorder_rom_pipe #(.CH(CH), .DW(DW), .DEPTH(3)) bDut (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(inValid), .in_ready_o(bReady),
    .mode_i(mode), .fwd_data_i(fwd), .inv_data_i(inv), .out_valid_o(bValid),
    .out_ready_i(outReady), .out_data_o(bData), .out_mode_o(bMode), .occ_o(bOcc)
`ifdef REORDER_PIPE_PARITY_EN
    , .par_err_o(bPar)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1; inValid = 1'b0; flush = 1'b0; outReady = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic inV, input logic md, input logic [W-1:0] f,
                              input logic [W-1:0] iv, input logic eV, input logic eM,
                              input logic [W-1:0] eD, input logic [1:0] eO);
    vec_t r;
    r.inV = inV; r.md = md; r.fwd = f; r.inv = iv;
    r.expV = eV; r.expMode = eM; r.expData = eD; r.expOcc = eO;
    return r;
  endfunction

  initial begin
    vec_t         vecs[16];
    logic [W-1:0] pA;
    logic [W-1:0] p5;
    int           got;

    errs = 0; checks = 0;
    pA = {128{4'hA}};
    p5 = {128{4'h5}};

    // Streaming 1..8 (inv all-ones must never be selected), then alternating modes.
    for (int k = 0; k < 8; k++) begin
      vecs[k] = mk(1'b1, 1'b0, W'(k + 1), '1, (k >= 1), 1'b0, W'(k), (k == 0) ? 2'd1 : 2'd2);
    end
    vecs[8]  = mk(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, W'(8), 2'd1);
    vecs[9]  = mk(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 2'd0);
    vecs[10] = mk(1'b1, 1'b0, pA, p5, 1'b0, 1'b0, '0, 2'd1);
    vecs[11] = mk(1'b1, 1'b1, pA, p5, 1'b1, 1'b0, pA, 2'd2);
    vecs[12] = mk(1'b1, 1'b0, pA, p5, 1'b1, 1'b1, p5, 2'd2);
    vecs[13] = mk(1'b1, 1'b1, pA, p5, 1'b1, 1'b0, pA, 2'd2);
    vecs[14] = mk(1'b0, 1'b0, pA, p5, 1'b1, 1'b1, p5, 2'd1);
    vecs[15] = mk(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 2'd0);

    rst = 1'b1; flush = 1'b0; inValid = 1'b0; mode = 1'b0; fwd = '0; inv = '0; outReady = 1'b1;
    tick();
    tick();
    chkb("in_ready during rst", aReady, 1'b0);
    rst = 1'b0;
    #1;
    chkb("reset out_valid", aValid, 1'b0);
    chkw("reset out_data", aData, '0);
    chkb("reset out_mode", aMode, 1'b0);
    chkw("reset occ", W'(aOcc), '0);
    chkb("reset in_ready A", aReady, 1'b1);
    chkb("reset in_ready B", bReady, 1'b1);

    for (int i = 0; i < 16; i++) begin
      inValid = vecs[i].inV; mode = vecs[i].md; fwd = vecs[i].fwd; inv = vecs[i].inv;
      tick();
      chkb($sformatf("vec%0d valid", i), aValid, vecs[i].expV);
      if (vecs[i].expV) begin
        chkw($sformatf("vec%0d data", i), aData, vecs[i].expData);
        chkb($sformatf("vec%0d mode", i), aMode, vecs[i].expMode);
      end
      chkw($sformatf("vec%0d occ", i), W'(aOcc), W'(vecs[i].expOcc));
    end

    // Back-pressure on the 3-deep pipe.
    doReset();
    outReady = 1'b0; inValid = 1'b1; mode = 1'b0; inv = '0;
    for (int c = 0; c < 5; c++) begin
      fwd = W'(16 + ((c < 3) ? c : 3));
      tick();
      if (c >= 2) begin
        chkb($sformatf("bp hold valid %0d", c), bValid, 1'b1);
        chkw($sformatf("bp hold data %0d", c), bData, W'(16));
      end
    end
    chkw("bp occ full", W'(bOcc), W'(3));
    chkb("bp in_ready", bReady, 1'b0);
    outReady = 1'b1;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 2) begin
        inValid = 1'b1; fwd = W'(19 + c);
      end else begin
        inValid = 1'b0;
      end
      if (bValid) begin
        chkw($sformatf("bp order %0d", got), bData, W'(16 + got));
        got++;
      end
      tick();
    end
    chkw("bp count", W'(got), W'(5));
    chkw("bp occ drained", W'(bOcc), '0);

    // Flush a full pipe while offering a word.
    outReady = 1'b0; inValid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      fwd = W'(32 + c);
      tick();
    end
    chkw("flush pre occ", W'(bOcc), W'(3));
    fwd = W'(35); flush = 1'b1; outReady = 1'b1;
    #1;
    chkb("flush in_ready", bReady, 1'b0);
    tick();
    flush = 1'b0; inValid = 1'b0;
    chkw("flush occ", W'(bOcc), '0);
    chkb("flush valid", bValid, 1'b0);
    inValid = 1'b1; fwd = W'(36);
    tick();
    inValid = 1'b0;
    chkb("post flush lat1", bValid, 1'b0);
    tick();
    tick();
    chkb("post flush valid", bValid, 1'b1);
    chkw("post flush data", bData, W'(36));
    tick();
    chkb("post flush drained", bValid, 1'b0);
    chkw("post flush occ", W'(bOcc), '0);

    // Reset with two words in flight in the 2-deep pipe.
    doReset();
    outReady = 1'b0; inValid = 1'b1; mode = 1'b1; fwd = '0; inv = W'(77);
    tick();
    inv = W'(78);
    tick();
    inValid = 1'b0;
    chkb("rst pre valid", aValid, 1'b1);
    chkb("rst pre mode", aMode, 1'b1);
    chkw("rst pre occ", W'(aOcc), W'(2));
    rst = 1'b1;
    tick();
    chkb("rst mid valid", aValid, 1'b0);
    chkw("rst mid data", aData, '0);
    chkb("rst mid mode", aMode, 1'b0);
    chkw("rst mid occ", W'(aOcc), '0);
    chkb("rst mid in_ready", aReady, 1'b0);
    rst = 1'b0; outReady = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chkb($sformatf("rst no stale %0d", c), aValid, 1'b0);
    end

`ifdef REORDER_PIPE_PARITY_EN
    begin
      logic [W+CH:0] pv;
      doReset();
      for (int c = 0; c < 1000; c++) begin
        inValid = 1'($urandom_range(0, 1));
        mode = 1'($urandom_range(0, 1));
        outReady = 1'($urandom_range(0, 1));
        for (int k = 0; k < 16; k++) begin
          fwd[k*32 +: 32] = $urandom;
          inv[k*32 +: 32] = $urandom;
        end
        tick();
      end
      inValid = 1'b0; outReady = 1'b1;
      tick(); tick(); tick();
      chkb("parity clean", aPar, 1'b0);
      doReset();
      outReady = 1'b0; inValid = 1'b1; mode = 1'b0; fwd = W'(5);
      tick();
      inValid = 1'b0;
      tick();
      pv = aDut.gStage[1].uStage.payload;
      force aDut.gStage[1].uStage.payload = pv ^ ((W + CH + 1)'(1) << (2 * DW));
      outReady = 1'b1;
      tick();
      release aDut.gStage[1].uStage.payload;
      chkb("parity flagged", aPar, 1'b1);
      tick(); tick(); tick();
      chkb("parity sticky", aPar, 1'b1);
      doReset();
      #1;
      chkb("parity cleared", aPar, 1'b0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
